// File: rtl/csi_hdmi_bridge_ctrl_if.sv
// Signal bundle between the CSI framing/FIFO side and the bridge sequencing controller.
// The master drives framing and occupancy; the slave (controller) drives sequencing outputs.
interface csi_hdmi_bridge_ctrl_if #(
  parameter int LEVEL_W = 12
);
  logic               csi_in_frame;
  logic               csi_in_line;
  logic [LEVEL_W-1:0] fifo_level;
  logic               hdmi_frame;
  logic               rgb_valid;
  logic               hdmi_reset_n;
  logic               fifo_flush;
  logic               locked;
  logic [7:0]         err_count;
  logic [1:0]         state;

  modport master (
    output csi_in_frame, csi_in_line, fifo_level, hdmi_frame,
    input  rgb_valid, hdmi_reset_n, fifo_flush, locked, err_count, state
  );

  modport slave (
    input  csi_in_frame, csi_in_line, fifo_level, hdmi_frame,
    output rgb_valid, hdmi_reset_n, fifo_flush, locked, err_count, state
  );
endinterface

// File: rtl/csi_hdmi_bridge_ctrl.sv
// CSI-to-HDMI bridge sequencer: tracks CSI framing, releases the HDMI timing generator,
// declares the RGB path valid, and flushes the pixel FIFO on overflow/underflow.
//
// state      | meaning
// WAIT_FRAME | idle, waiting for a fresh CSI frame start
// PRIME      | frame started, counting lines until the RGB path is valid
// RUN        | locked, pixels flowing to HDMI
// FLUSH      | FIFO flush held for FLUSH_CYCLES, then resync
module csi_hdmi_bridge_ctrl #(
  parameter int VALID_LINE   = 3,
  parameter int RELEASE_LINE = 1,
  parameter int MAX_LINES    = 1300,
  parameter int LEVEL_W      = 12,
  parameter int HI_WATER     = 3800,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                  csi_clk,
  input  logic                  reset,
  csi_hdmi_bridge_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [FC_W-1:0]    FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [10:0]        VALID_L    = 11'(VALID_LINE);
  localparam logic [10:0]        RELEASE_L  = 11'(RELEASE_LINE);
  localparam logic [10:0]        MAX_L      = 11'(MAX_LINES);
  localparam logic [LEVEL_W-1:0] HI_WATER_L = LEVEL_W'(HI_WATER);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    PRIME      = 2'd1,
    RUN        = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [10:0]     line_cnt_q, line_cnt_d;
  logic [7:0]      err_count_q, err_count_d;

  logic frame_dly_q, line_dly_q;
  logic hdmi_meta_q, hdmi_frame_s_q;
  logic rgb_valid_q, hdmi_reset_n_q, fifo_flush_q, locked_q;

  logic frame_rise, frame_fall, line_rise;
  logic counting, ovf, unf, err;

  assign frame_rise = bus.csi_in_frame & ~frame_dly_q;
  assign frame_fall = ~bus.csi_in_frame & frame_dly_q;
  assign line_rise  = bus.csi_in_line & ~line_dly_q;

  assign counting = (state_q == PRIME) || (state_q == RUN);
  assign ovf      = bus.fifo_level >= HI_WATER_L;
  assign unf      = (state_q == RUN) & bus.csi_in_frame & hdmi_frame_s_q
                    & (bus.fifo_level == '0);
  assign err      = counting & (ovf | unf);

  always_ff @(posedge csi_clk) begin
    if (reset) begin
      state_q        <= FLUSH;
      flush_cnt_q    <= '0;
      line_cnt_q     <= '0;
      err_count_q    <= '0;
      frame_dly_q    <= 1'b0;
      line_dly_q     <= 1'b0;
      hdmi_meta_q    <= 1'b0;
      hdmi_frame_s_q <= 1'b0;
      rgb_valid_q    <= 1'b0;
      hdmi_reset_n_q <= 1'b0;
      fifo_flush_q   <= 1'b1;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      line_cnt_q     <= line_cnt_d;
      err_count_q    <= err_count_d;
      frame_dly_q    <= bus.csi_in_frame;
      line_dly_q     <= bus.csi_in_line;
      hdmi_meta_q    <= bus.hdmi_frame;
      hdmi_frame_s_q <= hdmi_meta_q;
      rgb_valid_q    <= (state_q == RUN);
      hdmi_reset_n_q <= counting && (line_cnt_q >= RELEASE_L);
      fifo_flush_q   <= (state_q == FLUSH);
      locked_q       <= (state_q == RUN);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    line_cnt_d  = line_cnt_q;
    err_count_d = err_count_q;

    // Error outranks frame end, which outranks line-count progress.
    unique case (state_q)
      WAIT_FRAME: begin
        if (frame_rise) state_d = PRIME;
      end
      PRIME: begin
        if (err)                         state_d = FLUSH;
        else if (frame_fall)             state_d = WAIT_FRAME;
        else if (line_cnt_q >= VALID_L)  state_d = RUN;
      end
      RUN: begin
        if (err)             state_d = FLUSH;
        else if (frame_fall) state_d = WAIT_FRAME;
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = WAIT_FRAME;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = FLUSH;
    endcase

    // A line rising together with frame end belongs to no frame and is dropped.
    if (state_q == WAIT_FRAME && state_d == PRIME) begin
      line_cnt_d = '0;
    end else if (counting && line_rise && !err && !frame_fall && line_cnt_q < MAX_L) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end

    if (state_d == FLUSH && state_q != FLUSH && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  assign bus.rgb_valid    = rgb_valid_q;
  assign bus.hdmi_reset_n = hdmi_reset_n_q;
  assign bus.fifo_flush   = fifo_flush_q;
  assign bus.locked       = locked_q;
  assign bus.err_count    = err_count_q;
  assign bus.state        = state_q;

endmodule
